// File: rtl/alu_pkg.sv
// ============================================================================
//  Module  : alu_pkg
//  Brief   : Function-code encodings and width-derived limits for the mini ALU.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int ALU_WIDTH = 6;

    localparam logic [2:0] FXN_PASSA = 3'b000;
    localparam logic [2:0] FXN_PASSB = 3'b001;
    localparam logic [2:0] FXN_NEGA  = 3'b010;
    localparam logic [2:0] FXN_NEGB  = 3'b011;
    localparam logic [2:0] FXN_SLT   = 3'b100;
    localparam logic [2:0] FXN_XNOR  = 3'b101;
    localparam logic [2:0] FXN_ADD   = 3'b110;
    localparam logic [2:0] FXN_SUB   = 3'b111;

    localparam logic [ALU_WIDTH-1:0] MAX_POS = {1'b0, {(ALU_WIDTH-1){1'b1}}};
    localparam logic [ALU_WIDTH-1:0] MIN_NEG = {1'b1, {(ALU_WIDTH-1){1'b0}}};

endpackage

`default_nettype wire

// File: rtl/alu_addsub.sv
// ============================================================================
//  Module  : alu_addsub
//  Brief   : Shared signed adder/subtractor with two's-complement overflow flag.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_addsub #(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             ovf
);

    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_ext;

    assign w_b_eff = sub ? ~b : b;

    // Sign-extended one-bit-wider sum: the top two bits disagree exactly on overflow.
    assign w_ext = {a[WIDTH-1], a} + {w_b_eff[WIDTH-1], w_b_eff} + (WIDTH+1)'(cin);

    assign sum = w_ext[WIDTH-1:0];
    assign ovf = w_ext[WIDTH] ^ w_ext[WIDTH-1];

endmodule

`default_nettype wire

// File: rtl/alu_top.sv
// ============================================================================
//  Module  : alu_top
//  Brief   : Registered signed mini ALU (pass/negate/compare/XNOR/add/sub).
//            Define ALU_SAT_EN to clamp arithmetic results on overflow.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_top
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       fxn,
    output logic [WIDTH-1:0] X,
    output logic             out_vld,
    output logic             ovf,
    output logic             zero
);

    logic [WIDTH-1:0] w_add_a;
    logic [WIDTH-1:0] w_add_b;
    logic             w_add_sub;
    logic             w_add_cin;
    logic [WIDTH-1:0] w_sum;
    logic             w_add_ovf;

    logic [WIDTH-1:0] w_res;
    logic             w_arith;
    logic             w_lt;

    logic [WIDTH-1:0] x_d;
    logic             ovf_d;
    logic             zero_d;

    logic [WIDTH-1:0] x_q;
    logic             ovf_q;
    logic             zero_q;
    logic             vld_q;

    // Negation reuses the subtractor as 0 - operand.
    always_comb begin
        w_add_a   = A;
        w_add_b   = B;
        w_add_sub = 1'b0;
        w_add_cin = 1'b0;
        case (fxn)
            FXN_NEGA: begin
                w_add_a   = '0;
                w_add_b   = A;
                w_add_sub = 1'b1;
                w_add_cin = 1'b1;
            end
            FXN_NEGB: begin
                w_add_a   = '0;
                w_add_b   = B;
                w_add_sub = 1'b1;
                w_add_cin = 1'b1;
            end
            FXN_SUB: begin
                w_add_sub = 1'b1;
                w_add_cin = 1'b1;
            end
            default: ;
        endcase
    end

    alu_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .a   (w_add_a),
        .b   (w_add_b),
        .sub (w_add_sub),
        .cin (w_add_cin),
        .sum (w_sum),
        .ovf (w_add_ovf)
    );

    assign w_lt = $signed(A) < $signed(B);

    always_comb begin
        w_res   = A;
        w_arith = 1'b0;
        case (fxn)
            FXN_PASSA: w_res = A;
            FXN_PASSB: w_res = B;
            FXN_SLT: begin
                w_res    = '0;
                w_res[0] = w_lt;
            end
            FXN_XNOR:  w_res = ~(A ^ B);
            default: begin
                w_res   = w_sum;
                w_arith = 1'b1;
            end
        endcase
    end

    assign ovf_d = w_arith & w_add_ovf;

`ifdef ALU_SAT_EN
    localparam logic [WIDTH-1:0] c_MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] c_MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    // A wrapped negative result means the true value overflowed upward, and vice versa.
    assign x_d = ovf_d ? (w_sum[WIDTH-1] ? c_MAX_POS : c_MIN_NEG) : w_res;
`else
    assign x_d = w_res;
`endif

    assign zero_d = (x_d == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q    <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b1;
            vld_q  <= 1'b0;
        end else begin
            vld_q <= in_vld;
            if (in_vld) begin
                x_q    <= x_d;
                ovf_q  <= ovf_d;
                zero_q <= zero_d;
            end
        end
    end

    assign X       = x_q;
    assign ovf     = ovf_q;
    assign zero    = zero_q;
    assign out_vld = vld_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_top.sv
// ============================================================================
//  Module  : tb_alu_top
//  Brief   : Self-checking bench for alu_top (honours ALU_SAT_EN when defined).
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_top;

    localparam int TW      = 6;
    localparam int MAX_VAL = (1 << (TW - 1)) - 1;
    localparam int MIN_VAL = -(1 << (TW - 1));

    logic          clk;
    logic          rst_n;
    logic          in_vld;
    logic [TW-1:0] A;
    logic [TW-1:0] B;
    logic [2:0]    fxn;
    logic [TW-1:0] X;
    logic          out_vld;
    logic          ovf;
    logic          zero;

    int n_chk  = 0;
    int n_fail = 0;

    alu_top #(
        .WIDTH (TW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (in_vld),
        .A       (A),
        .B       (B),
        .fxn     (fxn),
        .X       (X),
        .out_vld (out_vld),
        .ovf     (ovf),
        .zero    (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact integer result, then range check decides ovf and wrap/clamp.
    function automatic logic [TW:0] model(input logic [TW-1:0] a, input logic [TW-1:0] b,
                                          input logic [2:0] f);
        int sa;
        int sb;
        int t;
        bit arith;
        logic [TW-1:0] x;
        logic o;
        sa = int'($signed(a));
        sb = int'($signed(b));
        arith = 1'b0;
        t = 0;
        case (f)
            3'd0: t = sa;
            3'd1: t = sb;
            3'd2: begin t = -sa;     arith = 1'b1; end
            3'd3: begin t = -sb;     arith = 1'b1; end
            3'd4: t = (sa < sb) ? 1 : 0;
            3'd5: t = int'({{(32-TW){1'b0}}, ~(a ^ b)});
            3'd6: begin t = sa + sb; arith = 1'b1; end
            default: begin t = sa - sb; arith = 1'b1; end
        endcase
        o = arith && (t > MAX_VAL || t < MIN_VAL);
`ifdef ALU_SAT_EN
        if (o) t = (t > MAX_VAL) ? MAX_VAL : MIN_VAL;
`endif
        x = t[TW-1:0];
        return {o, x};
    endfunction

    logic [TW:0]   m_now;
    logic [TW-1:0] exp_x;
    logic          exp_ovf;
    logic          exp_zero;
    logic          exp_vld;

    always_comb m_now = model(A, B, fxn);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_x    <= '0;
            exp_ovf  <= 1'b0;
            exp_zero <= 1'b1;
            exp_vld  <= 1'b0;
        end else begin
            exp_vld <= in_vld;
            if (in_vld) begin
                exp_x    <= m_now[TW-1:0];
                exp_ovf  <= m_now[TW];
                exp_zero <= (m_now[TW-1:0] == '0);
            end
        end
    end

    // Continuous compare of every output against the model, away from the clock edge.
    always @(negedge clk) begin
        n_chk = n_chk + 1;
        if ({X, ovf, zero, out_vld} !== {exp_x, exp_ovf, exp_zero, exp_vld}) begin
            n_fail = n_fail + 1;
            $display("FAIL cycle_cmp t=%0t: got X=%b ovf=%b zero=%b vld=%b, want X=%b ovf=%b zero=%b vld=%b",
                     $time, X, ovf, zero, out_vld, exp_x, exp_ovf, exp_zero, exp_vld);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk = n_chk + 1;
        if (got !== want) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    // Directed vector with hand-computed result; also pins the model to the same literal.
    task automatic vec(input string name, input logic [TW-1:0] a, input logic [TW-1:0] b,
                       input logic [2:0] f, input logic [TW-1:0] ex, input logic eo);
        @(negedge clk);
        A      = a;
        B      = b;
        fxn    = f;
        in_vld = 1'b1;
        @(posedge clk);
        #1;
        chk({name, ".X"},     32'(X),       32'(ex));
        chk({name, ".ovf"},   32'(ovf),     32'(eo));
        chk({name, ".zero"},  32'(zero),    32'(ex == '0));
        chk({name, ".vld"},   32'(out_vld), 32'd1);
        chk({name, ".model"}, 32'(exp_x),   32'(ex));
    endtask

    logic [TW-1:0] held;

    initial begin
        rst_n  = 1'b0;
        in_vld = 1'b0;
        A      = '0;
        B      = '0;
        fxn    = 3'b000;
        #12;
        chk("reset.X",    32'(X),       32'd0);
        chk("reset.zero", 32'(zero),    32'd1);
        chk("reset.vld",  32'(out_vld), 32'd0);
        chk("reset.ovf",  32'(ovf),     32'd0);
        rst_n = 1'b1;

        vec("passA",  6'b000100, 6'b100000, 3'b000, 6'b000100, 1'b0);
        vec("passB",  6'b000011, 6'b000000, 3'b001, 6'b000000, 1'b0);
        vec("negA",   6'b000011, 6'b000000, 3'b010, 6'b111101, 1'b0);
`ifdef ALU_SAT_EN
        vec("negMin", 6'b100000, 6'b000000, 3'b010, 6'b011111, 1'b1);
`else
        vec("negMin", 6'b100000, 6'b000000, 3'b010, 6'b100000, 1'b1);
`endif
        vec("negB",   6'b000000, 6'b100011, 3'b011, 6'b011101, 1'b0);
        vec("slt0",   6'b100101, 6'b001111, 3'b100, 6'b000001, 1'b0);
        vec("slt1",   6'b100100, 6'b101100, 3'b100, 6'b000001, 1'b0);
        vec("slt2",   6'b000001, 6'b000001, 3'b100, 6'b000000, 1'b0);
        vec("slt3",   6'b000001, 6'b000000, 3'b100, 6'b000000, 1'b0);
        vec("sltMM",  6'b100000, 6'b011111, 3'b100, 6'b000001, 1'b0);
        vec("xnor0",  6'b101100, 6'b110001, 3'b101, 6'b100010, 1'b0);
        vec("xnor1",  6'b000000, 6'b000000, 3'b101, 6'b111111, 1'b0);
        vec("add0",   6'b000001, 6'b000011, 3'b110, 6'b000100, 1'b0);
`ifdef ALU_SAT_EN
        vec("addOvf", 6'b101111, 6'b101100, 3'b110, 6'b100000, 1'b1);
        vec("addMax", 6'b011111, 6'b000001, 3'b110, 6'b011111, 1'b1);
`else
        vec("addOvf", 6'b101111, 6'b101100, 3'b110, 6'b011011, 1'b1);
        vec("addMax", 6'b011111, 6'b000001, 3'b110, 6'b100000, 1'b1);
`endif
        vec("add2",   6'b101100, 6'b000100, 3'b110, 6'b110000, 1'b0);
        vec("sub0",   6'b000000, 6'b000110, 3'b111, 6'b111010, 1'b0);
        vec("sub1",   6'b101111, 6'b101100, 3'b111, 6'b000011, 1'b0);
        vec("sub2",   6'b101100, 6'b000100, 3'b111, 6'b101000, 1'b0);
`ifdef ALU_SAT_EN
        vec("subOvf", 6'b011111, 6'b111111, 3'b111, 6'b011111, 1'b1);
`else
        vec("subOvf", 6'b011111, 6'b111111, 3'b111, 6'b100000, 1'b1);
`endif
        vec("subZ",   6'b000101, 6'b000101, 3'b111, 6'b000000, 1'b0);

        // Hold: in_vld low keeps result registers, drops out_vld.
        vec("preHold", 6'b010101, 6'b000000, 3'b000, 6'b010101, 1'b0);
        held = X;
        @(negedge clk);
        in_vld = 1'b0;
        A      = 6'b000111;
        fxn    = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        chk("hold.X",   32'(X),       32'(6'b010101));
        chk("hold.vld", 32'(out_vld), 32'd0);

        // Asynchronous reset between edges.
        vec("preRst", 6'b001010, 6'b000000, 3'b000, 6'b001010, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.X",    32'(X),       32'd0);
        chk("arst.zero", 32'(zero),    32'd1);
        chk("arst.vld",  32'(out_vld), 32'd0);
        @(negedge clk);
        #2;
        rst_n  = 1'b1;
        in_vld = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("postRst.X",   32'(X),       32'd0);
        chk("postRst.vld", 32'(out_vld), 32'd0);
        vec("afterRst", 6'b000010, 6'b000001, 3'b110, 6'b000011, 1'b0);

        @(negedge clk);
        in_vld = 1'b0;
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, %0d failures so far", n_fail);
        $fatal(1);
    end

endmodule

`default_nettype wire
